// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: one transaction at a time through IDLE/ACCESS/RESPOND.
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise port 0 wins ties.
module dmem_arbiter #(
   parameter int unsigned ACCESS_LAT = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [3:0]  p0_read,
   input  logic [2:0]  p0_write,
   input  logic [31:0] p0_address,
   input  logic [31:0] p0_writedata,
   output logic [31:0] p0_readdata,
   output logic        p0_busywait,
   input  logic [3:0]  p1_read,
   input  logic [2:0]  p1_write,
   input  logic [31:0] p1_address,
   input  logic [31:0] p1_writedata,
   output logic [31:0] p1_readdata,
   output logic        p1_busywait,
   output logic [3:0]  mem_read,
   output logic [2:0]  mem_write,
   output logic [31:0] mem_address,
   output logic [31:0] mem_writedata,
   input  logic [31:0] mem_readdata,
   input  logic        mem_busywait
);

   typedef enum logic [1:0] {StIdle, StAccess, StRespond} state_e;

   localparam logic [3:0] CntLast = 4'(ACCESS_LAT - 1);

   state_e      state_q, state_d;
   logic        grant_q, grant_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [3:0]  mem_read_d;
   logic [2:0]  mem_write_d;
   logic [31:0] mem_address_d, mem_writedata_d;
   logic [31:0] p0_readdata_d, p1_readdata_d;
   logic        valid0, valid1, winner;

   // A request is valid only when exactly one of read/write is raised.
   assign valid0 = p0_read[3] ^ p0_write[2];
   assign valid1 = p1_read[3] ^ p1_write[2];

`ifdef DMEM_ARB_ROUND_ROBIN_EN
   logic last_q, last_d;
   assign winner = (valid0 && valid1) ? ~last_q : valid1;
`else
   assign winner = ~valid0;
`endif

   assign p0_busywait = ~reset & valid0 & ~(state_q == StRespond && grant_q == 1'b0);
   assign p1_busywait = ~reset & valid1 & ~(state_q == StRespond && grant_q == 1'b1);

   always_comb begin
      state_d         = state_q;
      grant_d         = grant_q;
      cnt_d           = cnt_q;
      mem_read_d      = mem_read;
      mem_write_d     = mem_write;
      mem_address_d   = mem_address;
      mem_writedata_d = mem_writedata;
      p0_readdata_d   = p0_readdata;
      p1_readdata_d   = p1_readdata;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      last_d          = last_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (valid0 || valid1) begin
               state_d = StAccess;
               grant_d = winner;
               cnt_d   = 4'd0;
               if (winner) begin
                  mem_read_d      = p1_read;
                  mem_write_d     = p1_write;
                  mem_address_d   = p1_address;
                  mem_writedata_d = p1_writedata;
               end else begin
                  mem_read_d      = p0_read;
                  mem_write_d     = p0_write;
                  mem_address_d   = p0_address;
                  mem_writedata_d = p0_writedata;
               end
            end
         end
         StAccess: begin
            if (!mem_busywait) begin
               if (cnt_q == CntLast) begin
                  state_d     = StRespond;
                  mem_read_d  = 4'd0;
                  mem_write_d = 3'd0;
                  if (mem_read[3]) begin
                     if (grant_q) p1_readdata_d = mem_readdata;
                     else         p0_readdata_d = mem_readdata;
                  end
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                  last_d = grant_q;
`endif
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end
         StRespond: state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= StIdle;
         grant_q       <= 1'b1;
         cnt_q         <= 4'd0;
         mem_read      <= 4'd0;
         mem_write     <= 3'd0;
         mem_address   <= 32'd0;
         mem_writedata <= 32'd0;
         p0_readdata   <= 32'd0;
         p1_readdata   <= 32'd0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
         last_q        <= 1'b1;
`endif
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         cnt_q         <= cnt_d;
         mem_read      <= mem_read_d;
         mem_write     <= mem_write_d;
         mem_address   <= mem_address_d;
         mem_writedata <= mem_writedata_d;
         p0_readdata   <= p0_readdata_d;
         p1_readdata   <= p1_readdata_d;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
         last_q        <= last_d;
`endif
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter at ACCESS_LAT = 1; one record per clock cycle.
module tb_dmem_arbiter;

   localparam logic [3:0] RD = 4'b1010;
   localparam logic [2:0] WR = 3'b110;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
   localparam logic RR = 1'b1;
`else
   localparam logic RR = 1'b0;
`endif

   logic        clock, reset;
   logic [3:0]  p0_read, p1_read, mem_read;
   logic [2:0]  p0_write, p1_write, mem_write;
   logic [31:0] p0_address, p0_writedata, p0_readdata;
   logic [31:0] p1_address, p1_writedata, p1_readdata;
   logic [31:0] mem_address, mem_writedata, mem_readdata;
   logic        p0_busywait, p1_busywait, mem_busywait;

   dmem_arbiter #(.ACCESS_LAT(1)) dut (
      .clock(clock), .reset(reset),
      .p0_read(p0_read), .p0_write(p0_write), .p0_address(p0_address),
      .p0_writedata(p0_writedata), .p0_readdata(p0_readdata), .p0_busywait(p0_busywait),
      .p1_read(p1_read), .p1_write(p1_write), .p1_address(p1_address),
      .p1_writedata(p1_writedata), .p1_readdata(p1_readdata), .p1_busywait(p1_busywait),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
      .mem_busywait(mem_busywait)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   typedef struct {
      string       name;
      logic        rst;
      logic [3:0]  r0;
      logic [2:0]  w0;
      logic [31:0] a0, d0;
      logic [3:0]  r1;
      logic [31:0] a1, mrd;
      logic        mbw;
      logic [136:0] exp;
   } vec_t;

   vec_t vecs[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic add(input string name, input logic rst, input logic [3:0] r0,
                      input logic [2:0] w0, input logic [31:0] a0, d0,
                      input logic [3:0] r1, input logic [31:0] a1, mrd, input logic mbw,
                      input logic ebw0, ebw1, input logic [3:0] emr, input logic [2:0] emw,
                      input logic [31:0] ema, emwd, erd0, erd1);
      vec_t v;
      v.name = name; v.rst = rst; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
      v.r1 = r1; v.a1 = a1; v.mrd = mrd; v.mbw = mbw;
      v.exp = {ebw0, ebw1, emr, emw, ema, emwd, erd0, erd1};
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [136:0] act, exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   function automatic logic [136:0] observed();
      return {p0_busywait, p1_busywait, mem_read, mem_write, mem_address, mem_writedata,
              p0_readdata, p1_readdata};
   endfunction

   initial begin
      logic [31:0] ma_t, rd0_t, rd1_t;
      int n;
      ma_t  = RR ? 32'h30 : 32'h20;
      rd0_t = RR ? 32'hA5A5A5A5 : 32'h5A5A5A5A;
      rd1_t = RR ? 32'h5A5A5A5A : 32'hDEADBEEF;

      //   name          rst r0  w0  a0     d0            r1  a1     mrd           mbw
      //   bw0 bw1 mr  mw  ma     mwd           rd0           rd1
      add("reset",       1, RD, 0,  0,     0,            0,  0,     0,            0,
          0, 0, 0,  0,  0,     0,            0,            0);
      add("wr0_c0",      0, 0,  WR, 32'h10, 32'hDEADBEEF, 0, 0,     0,            0,
          1, 0, 0,  0,  0,     0,            0,            0);
      add("wr0_c1",      0, 0,  WR, 32'h10, 32'hDEADBEEF, 0, 0,     0,            0,
          1, 0, 0,  WR, 32'h10, 32'hDEADBEEF, 0,           0);
      add("wr0_c2",      0, 0,  WR, 32'h10, 32'hDEADBEEF, 0, 0,     0,            0,
          0, 0, 0,  0,  32'h10, 32'hDEADBEEF, 0,           0);
      add("rd1_c0",      0, 0,  0,  0,     0,            RD, 32'h10, 32'hDEADBEEF, 0,
          0, 1, 0,  0,  32'h10, 32'hDEADBEEF, 0,           0);
      add("rd1_c1",      0, 0,  0,  0,     0,            RD, 32'h10, 32'hDEADBEEF, 0,
          0, 1, RD, 0,  32'h10, 0,            0,            0);
      add("rd1_c2",      0, 0,  0,  0,     0,            RD, 32'h10, 32'hDEADBEEF, 0,
          0, 0, 0,  0,  32'h10, 0,            0,            32'hDEADBEEF);
      add("both_rw_c0",  0, RD, WR, 0,     0,            0,  0,     32'hDEADBEEF, 0,
          0, 0, 0,  0,  32'h10, 0,            0,            32'hDEADBEEF);
      add("both_rw_c1",  0, RD, WR, 0,     0,            0,  0,     32'hDEADBEEF, 0,
          0, 0, 0,  0,  32'h10, 0,            0,            32'hDEADBEEF);
      add("tie_c0",      0, RD, 0,  32'h20, 0,           RD, 32'h30, 32'hA5A5A5A5, 0,
          1, 1, 0,  0,  32'h10, 0,            0,            32'hDEADBEEF);
      add("tie_c1",      0, RD, 0,  32'h20, 0,           RD, 32'h30, 32'hA5A5A5A5, 0,
          1, 1, RD, 0,  32'h20, 0,            0,            32'hDEADBEEF);
      add("tie_c2",      0, RD, 0,  32'h20, 0,           RD, 32'h30, 32'hA5A5A5A5, 0,
          0, 1, 0,  0,  32'h20, 0,            32'hA5A5A5A5, 32'hDEADBEEF);
      add("tie_c3",      0, RD, 0,  32'h20, 0,           RD, 32'h30, 32'h5A5A5A5A, 0,
          1, 1, 0,  0,  32'h20, 0,            32'hA5A5A5A5, 32'hDEADBEEF);
      add("tie_c4",      0, RD, 0,  32'h20, 0,           RD, 32'h30, 32'h5A5A5A5A, 0,
          1, 1, RD, 0,  ma_t,  0,            32'hA5A5A5A5, 32'hDEADBEEF);
      add("tie_c5",      0, RD, 0,  32'h20, 0,           RD, 32'h30, 32'h5A5A5A5A, 0,
          RR, !RR, 0, 0, ma_t, 0,            rd0_t,        rd1_t);
      add("idle",        0, 0,  0,  0,     0,            0,  0,     0,            0,
          0, 0, 0,  0,  ma_t,  0,            rd0_t,        rd1_t);
      add("mbw_c0",      0, RD, 0,  32'h40, 0,           0,  0,     32'h0BADF00D, 0,
          1, 0, 0,  0,  ma_t,  0,            rd0_t,        rd1_t);
      add("mbw_c1",      0, RD, 0,  32'h40, 0,           0,  0,     32'h0BADF00D, 1,
          1, 0, RD, 0,  32'h40, 0,            rd0_t,        rd1_t);
      add("mbw_c2",      0, RD, 0,  32'h40, 0,           0,  0,     32'h0BADF00D, 1,
          1, 0, RD, 0,  32'h40, 0,            rd0_t,        rd1_t);
      add("mbw_c3",      0, RD, 0,  32'h40, 0,           0,  0,     32'h0BADF00D, 1,
          1, 0, RD, 0,  32'h40, 0,            rd0_t,        rd1_t);
      add("mbw_c4",      0, RD, 0,  32'h40, 0,           0,  0,     32'h0BADF00D, 0,
          1, 0, RD, 0,  32'h40, 0,            rd0_t,        rd1_t);
      add("mbw_c5",      0, RD, 0,  32'h40, 0,           0,  0,     32'h0BADF00D, 0,
          0, 0, 0,  0,  32'h40, 0,            32'h0BADF00D, rd1_t);
      add("rst_c0",      0, 0,  0,  0,     0,            RD, 32'h50, 32'hCAFEF00D, 0,
          0, 1, 0,  0,  32'h40, 0,            32'h0BADF00D, rd1_t);
      add("rst_c1",      1, 0,  0,  0,     0,            RD, 32'h50, 32'hCAFEF00D, 0,
          0, 0, RD, 0,  32'h50, 0,            32'h0BADF00D, rd1_t);
      add("rst_c2",      1, 0,  0,  0,     0,            RD, 32'h50, 32'hCAFEF00D, 0,
          0, 0, 0,  0,  0,     0,            0,            0);
      add("rst_c3",      0, 0,  0,  0,     0,            RD, 32'h50, 32'hCAFEF00D, 0,
          0, 1, 0,  0,  0,     0,            0,            0);
      add("rst_c4",      0, 0,  0,  0,     0,            RD, 32'h50, 32'hCAFEF00D, 0,
          0, 1, RD, 0,  32'h50, 0,            0,            0);
      add("rst_c5",      0, 0,  0,  0,     0,            RD, 32'h50, 32'hCAFEF00D, 0,
          0, 0, 0,  0,  32'h50, 0,            0,            32'hCAFEF00D);
      add("idle_end",    0, 0,  0,  0,     0,            0,  0,     0,            0,
          0, 0, 0,  0,  32'h50, 0,            0,            32'hCAFEF00D);

      reset = 1'b1;
      p0_read = '0; p0_write = '0; p0_address = '0; p0_writedata = '0;
      p1_read = '0; p1_write = '0; p1_address = '0; p1_writedata = '0;
      mem_readdata = '0; mem_busywait = 1'b0;
      repeat (2) @(posedge clock);

      foreach (vecs[i]) begin
         @(posedge clock);
         #1;
         reset        = vecs[i].rst;
         p0_read      = vecs[i].r0;
         p0_write     = vecs[i].w0;
         p0_address   = vecs[i].a0;
         p0_writedata = vecs[i].d0;
         p1_read      = vecs[i].r1;
         p1_address   = vecs[i].a1;
         mem_readdata = vecs[i].mrd;
         mem_busywait = vecs[i].mbw;
         @(negedge clock);
         check(vecs[i].name, observed(), vecs[i].exp);
      end

      // Store from port 0: latency ACCESS_LAT + 2 cycles, and readdata must not move.
      @(posedge clock);
      #1;
      p0_write     = WR;
      p0_address   = 32'h60;
      p0_writedata = 32'h12345678;
      mem_readdata = 32'hFFFFFFFF;
      n = 0;
      while (n < 20) begin
         @(negedge clock);
         n++;
         if (n == 2)
            check("lat_mem_drive", 137'({mem_write, mem_address, mem_writedata}),
                  137'({WR, 32'h60, 32'h12345678}));
         if (!p0_busywait) break;
      end
      check("lat_cycles", 137'(n), 137'(3));
      check("lat_rdata_kept", 137'({p0_readdata, p1_readdata}),
            137'({32'h0, 32'hCAFEF00D}));
      @(posedge clock);
      #1;
      p0_write = '0;
      @(negedge clock);
      check("lat_idle", 137'({p0_busywait, mem_write}), 137'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter ACCESS_LAT, default 1: number of ACCESS cycles per memory transaction, legal range 1..15.
REQ-002 The block SHALL have port clock, input, 1: system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-004 The block SHALL have port pN_read (N=0,1), input, 4: bit3 = read request, bits[2:0] = funct3.
REQ-005 The block SHALL have port pN_write, input, 3: bit2 = write request, bits[1:0] = funct3 size.
REQ-006 The block SHALL have port pN_address, input, 32: byte address.
REQ-007 The block SHALL have port pN_writedata, input, 32: store data.
REQ-008 The block SHALL have port pN_readdata, output, 32: registered load data.
REQ-009 The block SHALL have port pN_busywait, output, 1: stall to requester N.
REQ-010 The block SHALL have port mem_read, output, 4; mem_write, output, 3; mem_address, output, 32; mem_writedata, output, 32: registered drive to the data memory.
REQ-011 The block SHALL have port mem_readdata, input, 32, and mem_busywait, input, 1: data memory response.
Port 0 is the CPU data port; port 1 is the secondary master (loader/accelerator).

Function
REQ-012 A valid request on port N SHALL be exactly one of pN_read[3], pN_write[2]; both set or both clear SHALL be ignored, with pN_busywait = 0 and no memory access.
REQ-013 The FSM SHALL have states IDLE, ACCESS and RESPOND.
REQ-014 IDLE -> ACCESS on any valid request: latch the winner's read/write/address/writedata into the mem_* registers and record the grant.
REQ-015 IDLE with no valid request SHALL remain in IDLE.
REQ-016 ACCESS SHALL last ACCESS_LAT cycles, counted by a 4-bit counter; the counter SHALL hold while mem_busywait = 1.
REQ-017 When the count is done and mem_busywait = 0, the FSM SHALL go ACCESS -> RESPOND, capture mem_readdata into the granted pN_readdata (reads only) and zero the mem_read/mem_write registers.
REQ-018 RESPOND -> IDLE unconditionally after one cycle.
REQ-019 pN_busywait SHALL be combinational: = valid_N AND NOT (state == RESPOND AND grant == N).
REQ-020 A newly asserted request SHALL see busywait in its first cycle.
REQ-021 Latency from request to busywait low SHALL be ACCESS_LAT + 2 cycles with mem_busywait = 0.
REQ-022 Requesters SHALL hold their inputs stable while busywait = 1; the block SHALL NOT re-sample during ACCESS.
REQ-023 The losing port SHALL keep busywait = 1 and SHALL be arbitrated in the next IDLE.
REQ-024 mem_read and mem_write SHALL be zero in every state except ACCESS.
REQ-025 pN_readdata SHALL hold its value until that port's next completed read; writes SHALL NOT alter it.

Reset
REQ-026 While reset = 1 the FSM SHALL enter IDLE on the next edge and the grant/last-served pointer SHALL be set to port 1, so port 0 has priority on a first tie.
REQ-027 While reset = 1 the counter, mem_read, mem_write, mem_address, mem_writedata, p0_readdata and p1_readdata SHALL be cleared to 0.
REQ-028 pN_busywait SHALL be forced to 0 while reset = 1.
REQ-029 Reset asserted mid-ACCESS SHALL abort the transaction, with no readdata update.

Configuration
REQ-030 The block SHALL support a preprocessor macro DMEM_ARB_ROUND_ROBIN_EN.
REQ-031 With DMEM_ARB_ROUND_ROBIN_EN defined, on a tie the block SHALL grant the port not recorded as last-served, and the last-served pointer SHALL update on entry to RESPOND.
REQ-032 With DMEM_ARB_ROUND_ROBIN_EN undefined, port 0 SHALL always win a tie, and port 1 MAY starve.

Verification (ACCESS_LAT=1, cycle 0 = request cycle)
REQ-033 Port 0 write 0xDEADBEEF to 0x10 SHALL produce mem_write[2]=1 and mem_address=0x10 in cycle 1, with p0_busywait = 1,1,0 over cycles 0-2.
REQ-034 A subsequent port 1 read of 0x10 SHALL produce p1_readdata = 0xDEADBEEF in cycle 2 and p1_busywait = 0 in cycle 2.
REQ-035 With both ports reading in cycle 0 and port 0 re-requesting in cycle 3: without the macro, port 0 SHALL be served again (cycle 5) and p1_busywait SHALL stay 1; with the macro, port 1 SHALL be served (busywait low in cycle 5).
REQ-036 p0_read[3]=1 together with p0_write[2]=1 SHALL produce no mem access, p0_busywait = 0 and the FSM remaining in IDLE.
REQ-037 mem_busywait held high for 3 cycles during ACCESS SHALL extend ACCESS by 3, putting RESPOND in cycle 5.
REQ-038 Reset pulsed in cycle 1 of a read SHALL return the FSM to IDLE with mem_read = 0, pN_readdata = 0 and pN_busywait = 0 during reset.
